// File: rtl/hart_puls_gen_pkg.sv
// Shared definitions for the heartbeat pulse generator and the heart-rate counter.
// Both sides use the same window length (2^HART_ACC_W clocks).
package hart_pkg;

  localparam int HART_ACC_W  = 28;
  localparam int HART_FREQ_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } hart_state_e;

endpackage

// File: rtl/hart_puls_gen_if.sv
// Control and pulse-output bundle of the heartbeat pulse generator.
interface hart_puls_gen_if #(
  parameter int FREQ_W = hart_pkg::HART_FREQ_W
);

  logic              Inschakel;
  logic [FREQ_W-1:0] Freq_in;
  logic              Laden;
  logic              Uitgang;
  logic              Tik;
  logic              Venster;
  logic              Actief;

  modport master (
    output Inschakel, Freq_in, Laden,
    input  Uitgang, Tik, Venster, Actief
  );

  modport slave (
    input  Inschakel, Freq_in, Laden,
    output Uitgang, Tik, Venster, Actief
  );

endinterface

// File: rtl/hart_puls_gen_puls_rekker.sv
// Retriggerable pulse stretcher: every Trig (re)loads PULSE_LEN, output is high
// while the counter is non-zero, so overlapping beats merge into one pulse.
module puls_rekker #(
  parameter int PULSE_LEN = 1000
) (
  input  logic CLK,
  input  logic Reset,
  input  logic Trig,
  output logic Uit
);

  localparam int CNT_W = $clog2(PULSE_LEN + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cnt <= '0;
    end else if (Trig) begin
      cnt <= CNT_W'(PULSE_LEN);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign Uit = (cnt != '0);

endmodule

// File: rtl/hart_puls_gen.sv
// Heartbeat pulse generator: an NCO turns a per-window beat count into exactly
// that many one-clock ticks per window, each stretched into a visible pulse.
module hart_puls_gen
  import hart_pkg::*;
#(
  parameter int ACC_W     = HART_ACC_W,
  parameter int FREQ_W    = HART_FREQ_W,
  parameter int PULSE_LEN = 1000
) (
  input  logic            CLK,
  input  logic            Reset,
  hart_puls_gen_if.slave  bus
);

  hart_state_e       state;
  hart_state_e       state_next;

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  c;
  logic [ACC_W:0]    sum;
  logic [FREQ_W-1:0] freq_r;
  logic [FREQ_W-1:0] freq_pend;
  logic [FREQ_W-1:0] freq_next_win;
  logic              boundary;
  logic              tik;
  logic              venster;
  logic              uit;

  // ACC wraps back to 0 at every boundary since Freq_r * 2^ACC_W is a whole
  // number of wraps; that is what makes the tick count per window exact.
  assign sum           = {1'b0, acc} + {{(ACC_W + 1 - FREQ_W){1'b0}}, freq_r};
  assign boundary      = (state == RUN) && (c == '1);
  assign freq_next_win = bus.Laden ? bus.Freq_in : freq_pend;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.Inschakel && (freq_r != '0)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (!bus.Inschakel) begin
          state_next = IDLE;
        end else if (boundary && (freq_next_win == '0)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A new rate only takes effect at a window boundary while running, so each
  // window carries a single rate; a strobe on the boundary itself wins.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      acc       <= '0;
      c         <= '0;
      freq_r    <= '0;
      freq_pend <= '0;
      tik       <= 1'b0;
      venster   <= 1'b0;
    end else begin
      if (bus.Laden) begin
        freq_pend <= bus.Freq_in;
      end

      if (state == IDLE) begin
        freq_r <= freq_pend;
      end else if (boundary) begin
        freq_r <= freq_next_win;
      end

      if ((state == RUN) && bus.Inschakel) begin
        acc     <= sum[ACC_W-1:0];
        c       <= c + ACC_W'(1);
        tik     <= sum[ACC_W];
        venster <= (c == '1);
      end else begin
        acc     <= '0;
        c       <= '0;
        tik     <= 1'b0;
        venster <= 1'b0;
      end
    end
  end

  puls_rekker #(
    .PULSE_LEN(PULSE_LEN)
  ) u_rekker (
    .CLK  (CLK),
    .Reset(Reset),
    .Trig (tik),
    .Uit  (uit)
  );

  // Gating with RUN truncates a pulse on the edge that leaves RUN.
  assign bus.Uitgang = uit && (state == RUN);
  assign bus.Tik     = tik;
  assign bus.Venster = venster;
  assign bus.Actief  = (state == RUN);

endmodule

// File: tb/tb_hart_puls_gen.sv
// Self-checking bench for hart_puls_gen: beat-count table, multi-cycle corner
// sequences and random stimulus against a window/phase reference model.
module tb_hart_puls_gen;

  localparam int ACC_W  = 8;
  localparam int FREQ_W = 8;
  localparam int PL     = 4;
  localparam int WIN    = 1 << ACC_W;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  hart_puls_gen_if #(.FREQ_W(FREQ_W)) bus ();

  hart_puls_gen #(
    .ACC_W    (ACC_W),
    .FREQ_W   (FREQ_W),
    .PULSE_LEN(PL)
  ) dut (
    .CLK  (clk),
    .Reset(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: position inside the window and the applied rate.
  bit m_run;
  int m_rate, m_pend, m_n, m_age;
  bit m_tik, m_ven;

  typedef struct {
    int fin;
    int first;
    int tiks;
    int uit_cnt;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("[TB] FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  function automatic int beats_upto(input int n, input int rate);
    return (n * rate) / WIN;
  endfunction

  task automatic model_reset();
    m_run  = 0;
    m_rate = 0;
    m_pend = 0;
    m_n    = 0;
    m_age  = 1000;
    m_tik  = 0;
    m_ven  = 0;
  endtask

  task automatic model_step(input bit ins, input bit ld, input int fin);
    bit old_tik;
    int n1;
    old_tik = m_tik;
    if (!m_run) begin
      m_run  = ins && (m_rate != 0);
      m_rate = m_pend;
      m_n    = 0;
      m_tik  = 0;
      m_ven  = 0;
    end else begin
      n1 = m_n + 1;
      if (ins) begin
        m_tik = beats_upto(n1, m_rate) != beats_upto(m_n, m_rate);
        m_ven = (n1 == WIN);
        m_n   = n1 % WIN;
      end else begin
        m_tik = 0;
        m_ven = 0;
        m_n   = 0;
      end
      if (n1 == WIN || (!ins && n1 == WIN)) begin
        m_rate = ld ? fin : m_pend;
        if (m_rate == 0) m_run = 0;
      end
      if (!ins) m_run = 0;
    end
    if (ld) m_pend = fin;
    if (old_tik) m_age = 1;
    else if (m_age < 1000) m_age++;
  endtask

  function automatic int exp_vec();
    bit uit;
    uit = m_run && (m_age >= 1) && (m_age <= PL);
    return {28'd0, uit, m_tik, m_ven, m_run};
  endfunction

  function automatic int dut_vec();
    return {28'd0, bus.Uitgang, bus.Tik, bus.Venster, bus.Actief};
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!rst_n) model_reset();
    else model_step(bus.Inschakel, bus.Laden, int'(bus.Freq_in));
    #1;
    check("model {Uitgang,Tik,Venster,Actief}", dut_vec(), exp_vec());
  endtask

  task automatic applyStimulus(input bit ins, input bit ld, input int fin);
    bus.Inschakel = ins;
    bus.Laden     = ld;
    bus.Freq_in   = FREQ_W'(fin);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    applyStimulus(0, 0, 0);
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic start_run(input int f);
    applyStimulus(0, 1, f);
    tick();
    applyStimulus(0, 0, 0);
    tick();
    applyStimulus(1, 0, 0);
    tick();
    check("Actief on RUN entry", bus.Actief, 1);
  endtask

  task automatic wait_uitgang(input string name);
    int w;
    w = 0;
    while (!bus.Uitgang && w < 300) begin
      tick();
      w++;
    end
    check(name, bus.Uitgang, 1);
  endtask

  initial begin
    int first, tiks, uits, cnt1, cnt2, cnt3;
    tbl[0] = '{fin: 4,   first: 64,  tiks: 4,   uit_cnt: 12};
    tbl[1] = '{fin: 3,   first: 86,  tiks: 3,   uit_cnt: 8};
    tbl[2] = '{fin: 255, first: 2,   tiks: 255, uit_cnt: 254};
    tbl[3] = '{fin: 1,   first: 256, tiks: 1,   uit_cnt: 0};
    tbl[4] = '{fin: 128, first: 2,   tiks: 128, uit_cnt: 254};
    tbl[5] = '{fin: 5,   first: 52,  tiks: 5,   uit_cnt: 16};

    model_reset();
    do_reset();
    check("outputs after reset", dut_vec(), 0);

    // Enabled but no rate ever loaded: stays idle, no ticks.
    tiks = 0;
    applyStimulus(0, 0, 0);
    for (int k = 0; k < 1000; k++) begin
      tick();
      tiks += int'(bus.Tik);
    end
    check("tiks while idle", tiks, 0);
    check("Actief while idle", bus.Actief, 0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      start_run(tbl[i].fin);
      first = 0; tiks = 0; uits = 0;
      for (int k = 1; k <= WIN; k++) begin
        tick();
        if (bus.Tik && first == 0) first = k;
        tiks += int'(bus.Tik);
        uits += int'(bus.Uitgang);
        if (k == WIN) check($sformatf("f=%0d Tik+Venster at last clock", tbl[i].fin),
                            {bus.Tik, bus.Venster}, 3);
      end
      check($sformatf("f=%0d first Tik", tbl[i].fin), first, tbl[i].first);
      check($sformatf("f=%0d Tiks per window", tbl[i].fin), tiks, tbl[i].tiks);
      check($sformatf("f=%0d Uitgang clocks", tbl[i].fin), uits, tbl[i].uit_cnt);
    end

    // Pulse shape at rate 4: Tik at 64, Uitgang on clocks 65..68 only.
    do_reset();
    start_run(4);
    repeat (64) tick();
    check("Tik at clock 64", bus.Tik, 1);
    for (int k = 65; k <= 69; k++) begin
      tick();
      check($sformatf("Uitgang at clock %0d", k), bus.Uitgang, (k <= 68) ? 1 : 0);
    end

    // Mid-window reload, reload on the boundary, then rate 0 ends the run.
    do_reset();
    start_run(4);
    cnt1 = 0; cnt2 = 0; cnt3 = 0;
    for (int k = 1; k <= 3 * WIN; k++) begin
      if (k == 100)      applyStimulus(1, 1, 8);
      else if (k == 512) applyStimulus(1, 1, 2);
      else if (k == 600) applyStimulus(1, 1, 0);
      else               applyStimulus(1, 0, 0);
      tick();
      if (k <= WIN) cnt1 += int'(bus.Tik);
      else if (k <= 2 * WIN) cnt2 += int'(bus.Tik);
      else cnt3 += int'(bus.Tik);
      if (k == 3 * WIN - 1) check("Actief before rate-0 boundary", bus.Actief, 1);
      if (k == 3 * WIN) begin
        check("Venster at rate-0 boundary", bus.Venster, 1);
        check("Actief after rate-0 boundary", bus.Actief, 0);
      end
    end
    check("window 1 tiks (rate 4)", cnt1, 4);
    check("window 2 tiks (rate 8)", cnt2, 8);
    check("window 3 tiks (boundary load 2)", cnt3, 2);

    // Disable mid-pulse truncates Uitgang on the next edge.
    do_reset();
    start_run(4);
    wait_uitgang("Uitgang reached before disable");
    applyStimulus(0, 0, 0);
    tick();
    check("Uitgang after disable", bus.Uitgang, 0);
    check("Actief after disable", bus.Actief, 0);

    // Asynchronous reset between edges clears outputs without a clock.
    do_reset();
    start_run(4);
    wait_uitgang("Uitgang reached before async reset");
    #2 rst_n = 1'b0;
    #1;
    check("outputs after async reset", dut_vec(), 0);
    model_reset();
    #3 rst_n = 1'b1;
    applyStimulus(0, 0, 0);
    tick();

    // Random enable / load traffic against the model.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      int sel, f;
      sel = int'($urandom_range(0, 9));
      f = (sel < 2) ? 0 : (sel < 6) ? int'($urandom_range(1, 8)) :
          (sel == 6) ? 255 : int'($urandom_range(0, 255));
      applyStimulus(($urandom % 60) != 0, ($urandom % 150) == 0, f);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
